// File: rtl/receiver_if.sv
// -----------------------------------------------------------------------------
// receiver_if
// Bus-side handshake between the UART receive half and its host.
//   r_read    : host -> receiver, one-cycle pulse consuming r_data and clearing
//               r_ready / overrun
//   r_data    : receiver -> host, last received byte
//   r_ready   : receiver -> host, unread byte present
//   frame_err : receiver -> host, stop bit of the last completed frame was 0
//   overrun   : receiver -> host, a byte completed while r_ready was still 1
// Modports: slave = receiver side, master = host side.
// -----------------------------------------------------------------------------
interface receiver_if;
    logic       r_read;
    logic [7:0] r_data;
    logic       r_ready;
    logic       frame_err;
    logic       overrun;

    modport slave (
        input  r_read,
        output r_data,
        output r_ready,
        output frame_err,
        output overrun
    );

    modport master (
        output r_read,
        input  r_data,
        input  r_ready,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/receiver.sv
// -----------------------------------------------------------------------------
// receiver
// UART receive half: recovers 8N1 frames from the asynchronous rxd line using
// the oversampled sample_enable from the shared baud-rate generator, and holds
// each byte with a ready flag plus framing / overrun status.
//
// Parameters:
//   OVERSAMPLE    : sample_enable ticks per bit (even, >= 8), default 16
// Ports:
//   clk           : single clock
//   reset         : asynchronous, active-low reset
//   sample_enable : one-cycle pulse at OVERSAMPLE x baud
//   rxd           : serial line, idles high, asynchronous to clk
//   bus           : receiver_if.slave (r_read, r_data, r_ready, frame_err,
//                   overrun)
// Build option:
//   RX_MAJORITY_EN : when defined, each bit decision is the 2-of-3 majority of
//                    the synchronized line at tc = MID-1, MID, MID+1 and is
//                    applied at MID+1; otherwise a single sample at MID.
// -----------------------------------------------------------------------------
module receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sample_enable,
    input  logic         rxd,
    receiver_if.slave    bus
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TC_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TC_MID  = TW'(OVERSAMPLE / 2);
`ifdef RX_MAJORITY_EN
    localparam logic [TW-1:0] TC_DEC  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] TC_PRE  = TW'(OVERSAMPLE / 2 - 1);
`else
    localparam logic [TW-1:0] TC_DEC  = TC_MID;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q,     state_d;
    logic            sync1_q,     sync1_d;
    logic            rxd_s_q,     rxd_s_d;
    logic [TW-1:0]   tc_q,        tc_d;
    logic [2:0]      bc_q,        bc_d;
    logic [7:0]      shift_q,     shift_d;
    logic [7:0]      r_data_q,    r_data_d;
    logic            r_ready_q,   r_ready_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q,   overrun_d;

    logic            sample;
    logic            decide;
    logic            wrap;
    logic [TW-1:0]   tc_inc;

`ifdef RX_MAJORITY_EN
    // Earlier two votes of the 2-of-3 decision; the third is the live rxd_s.
    logic            vote_a_q,    vote_a_d;
    logic            vote_b_q,    vote_b_d;
    assign sample = (vote_a_q & vote_b_q) | (vote_a_q & rxd_s_q) | (vote_b_q & rxd_s_q);
`else
    assign sample = rxd_s_q;
`endif

    assign decide = sample_enable && (tc_q == TC_DEC);
    assign wrap   = sample_enable && (tc_q == TC_LAST);
    // Explicit wrap so a non-power-of-two OVERSAMPLE still counts correctly.
    assign tc_inc = (tc_q == TC_LAST) ? '0 : tc_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        sync1_d     = rxd;
        rxd_s_d     = sync1_q;
        tc_d        = tc_q;
        bc_d        = bc_q;
        shift_d     = shift_q;
        r_data_d    = r_data_q;
        r_ready_d   = r_ready_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
`ifdef RX_MAJORITY_EN
        vote_a_d    = vote_a_q;
        vote_b_d    = vote_b_q;
        if (sample_enable && tc_q == TC_PRE) vote_a_d = rxd_s_q;
        if (sample_enable && tc_q == TC_MID) vote_b_d = rxd_s_q;
`endif

        // overrun can only be set while r_ready is 1, so clearing both
        // unconditionally makes a read with nothing pending a no-op.
        if (bus.r_read) begin
            r_ready_d = 1'b0;
            overrun_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (sample_enable && !rxd_s_q) begin
                    tc_d    = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (sample_enable) tc_d = tc_inc;
                if (decide && sample) begin
                    state_d = S_IDLE;   // false start (glitch)
                    tc_d    = '0;
                end else if (wrap) begin
                    state_d = S_DATA;
                    bc_d    = '0;
                end
            end
            S_DATA: begin
                if (sample_enable) tc_d = tc_inc;
                if (decide) shift_d = {sample, shift_q[7:1]};
                if (wrap) begin
                    bc_d = bc_q + 1'b1;
                    if (bc_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (sample_enable) tc_d = tc_inc;
                if (decide) begin
                    r_data_d    = shift_q;
                    r_ready_d   = 1'b1;
                    frame_err_d = ~sample;
                    overrun_d   = r_ready_q & ~bus.r_read;
                    // Leaving at mid-stop lets the next start edge be seen
                    // during the second half of a single stop bit.
                    tc_d        = '0;
                    state_d     = sample ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                // A line held low must go high before a new start is armed.
                if (sample_enable && rxd_s_q) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                tc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            rxd_s_q     <= 1'b1;
            tc_q        <= '0;
            bc_q        <= '0;
            shift_q     <= '0;
            r_data_q    <= 8'h00;
            r_ready_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef RX_MAJORITY_EN
            vote_a_q    <= 1'b1;
            vote_b_q    <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rxd_s_q     <= rxd_s_d;
            tc_q        <= tc_d;
            bc_q        <= bc_d;
            shift_q     <= shift_d;
            r_data_q    <= r_data_d;
            r_ready_q   <= r_ready_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef RX_MAJORITY_EN
            vote_a_q    <= vote_a_d;
            vote_b_q    <= vote_b_d;
`endif
        end
    end

    assign bus.r_data    = r_data_q;
    assign bus.r_ready   = r_ready_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_receiver.sv
// -----------------------------------------------------------------------------
// tb_receiver
// Directed bench for the UART receiver, OVERSAMPLE=16, sample_enable every
// 4 clk. rxd is changed at the start of each tick period so the 2-flop
// synchronizer has settled before that period's sample_enable edge.
// Frame layout in ticks from the first low tick: start 0..15, data bit i
// 16+16i..31+16i, stop 144..159.
// -----------------------------------------------------------------------------
module tb_receiver;

    logic clk = 1'b0;
    logic reset;
    logic sample_enable;
    logic rxd;

    int total = 0;
    int bad   = 0;

    receiver_if bus_if ();

    receiver #(.OVERSAMPLE(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_enable (sample_enable),
        .rxd           (rxd),
        .bus           (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    // One sample_enable period: drive rxd, pulse sample_enable on the 4th clk.
    task automatic tick(input logic v);
        rxd           = v;
        sample_enable = 1'b0;
        repeat (3) @(negedge clk);
        sample_enable = 1'b1;
        @(negedge clk);
        sample_enable = 1'b0;
    endtask

    task automatic line(input logic v, input int n);
        for (int i = 0; i < n; i++) tick(v);
    endtask

    // Drives the first n_ticks ticks of a frame; spike forces one tick low.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input int spike, input int n_ticks);
        logic v;
        $display("frame d=%0h stop=%0b spike=%0d ticks=%0d", d, stop_bit, spike, n_ticks);
        for (int t = 0; t < n_ticks; t++) begin
            if (t < 16)       v = 1'b0;
            else if (t < 144) v = d[(t - 16) / 16];
            else              v = stop_bit;
            if (t == spike)   v = 1'b0;
            tick(v);
        end
    endtask

    task automatic read_pulse();
        bus_if.r_read = 1'b1;
        @(negedge clk);
        bus_if.r_read = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset         = 1'b0;
        sample_enable = 1'b0;
        rxd           = 1'b1;
        bus_if.r_read = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data",  32'(bus_if.r_data),    32'h00);
        chk("rst_ready", 32'(bus_if.r_ready),   32'h0);
        chk("rst_ferr",  32'(bus_if.frame_err), 32'h0);
        chk("rst_ovr",   32'(bus_if.overrun),   32'h0);
        reset = 1'b1;
        line(1'b1, 4);

        // Single frame 0xA5, then read.
        send_frame(8'hA5, 1'b1, -1, 160);
        chk("a5_data",  32'(bus_if.r_data),    32'hA5);
        chk("a5_ready", 32'(bus_if.r_ready),   32'h1);
        chk("a5_ferr",  32'(bus_if.frame_err), 32'h0);
        chk("a5_ovr",   32'(bus_if.overrun),   32'h0);
        read_pulse();
        chk("a5_read_ready", 32'(bus_if.r_ready), 32'h0);
        chk("a5_read_data",  32'(bus_if.r_data),  32'hA5);
        line(1'b1, 4);

        // Back-to-back 0x3C, 0xC3 without reading: overrun.
        send_frame(8'h3C, 1'b1, -1, 160);
        chk("3c_data", 32'(bus_if.r_data),  32'h3C);
        chk("3c_ovr",  32'(bus_if.overrun), 32'h0);
        send_frame(8'hC3, 1'b1, -1, 160);
        chk("c3_data",  32'(bus_if.r_data),    32'hC3);
        chk("c3_ready", 32'(bus_if.r_ready),   32'h1);
        chk("c3_ovr",   32'(bus_if.overrun),   32'h1);
        chk("c3_ferr",  32'(bus_if.frame_err), 32'h0);
        read_pulse();
        chk("c3_read_ready", 32'(bus_if.r_ready), 32'h0);
        chk("c3_read_ovr",   32'(bus_if.overrun), 32'h0);
        line(1'b1, 4);

        // 0x55 with a low stop bit and the line held low (break).
        send_frame(8'h55, 1'b0, -1, 160);
        line(1'b0, 48);
        chk("brk_data",  32'(bus_if.r_data),    32'h55);
        chk("brk_ferr",  32'(bus_if.frame_err), 32'h1);
        chk("brk_ready", 32'(bus_if.r_ready),   32'h1);
        read_pulse();
        chk("brk_read_ferr", 32'(bus_if.frame_err), 32'h1);
        line(1'b0, 200);
        chk("brk_no_retrig", 32'(bus_if.r_ready), 32'h0);
        line(1'b1, 20);
        chk("brk_idle_ready", 32'(bus_if.r_ready), 32'h0);

        // Short low glitch on idle line: must be rejected, then frame works.
        line(1'b0, 4);
        line(1'b1, 40);
        chk("glitch_ready", 32'(bus_if.r_ready), 32'h0);
        send_frame(8'h5A, 1'b1, -1, 160);
        chk("after_glitch_data",  32'(bus_if.r_data),    32'h5A);
        chk("after_glitch_ready", 32'(bus_if.r_ready),   32'h1);
        chk("after_glitch_ferr",  32'(bus_if.frame_err), 32'h0);

        // Reset during data bit 4 (r_ready still 1 from 0x5A).
        send_frame(8'h81, 1'b1, -1, 88);
        #1 reset = 1'b0;
        #1;
        chk("midrst_data",  32'(bus_if.r_data),    32'h00);
        chk("midrst_ready", 32'(bus_if.r_ready),   32'h0);
        chk("midrst_ovr",   32'(bus_if.overrun),   32'h0);
        chk("midrst_ferr",  32'(bus_if.frame_err), 32'h0);
        @(negedge clk);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        line(1'b1, 8);
        chk("post_rst_ready", 32'(bus_if.r_ready), 32'h0);
        send_frame(8'h81, 1'b1, -1, 160);
        chk("81_data",  32'(bus_if.r_data),  32'h81);
        chk("81_ready", 32'(bus_if.r_ready), 32'h1);
        chk("81_ovr",   32'(bus_if.overrun), 32'h0);
        read_pulse();
        line(1'b1, 4);

        // 0xFF with a one-tick low spike at tc=MID of bit 2 (tick 17+32+8).
        send_frame(8'hFF, 1'b1, 57, 160);
`ifdef RX_MAJORITY_EN
        chk("spike_data", 32'(bus_if.r_data), 32'hFF);
`else
        chk("spike_data", 32'(bus_if.r_data), 32'hFB);
`endif
        chk("spike_ready", 32'(bus_if.r_ready), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
